// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl : run/drain sequencer, load-use stall and MEM-redirect squash
//                 control with saturating performance counters.  Rev 1.0
// ============================================================================
module pipeline_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  enable,
   input  logic                  clr_cnt,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  id_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] id_ex_rt,
   input  logic                  ex_mem_branch,
   input  logic                  ex_mem_zero,
   input  logic                  ex_mem_jump,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic [1:0]            state,
   output logic [CNT_W-1:0]      cycle_cnt,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10
   } state_t;

   localparam int                  c_drain_w    = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [c_drain_w-1:0] c_drain_load = c_drain_w'(DRAIN_CYCLES);

   state_t                 r_state, w_state_nxt;
   logic [c_drain_w-1:0]   r_drain, w_drain_nxt;
   logic                   w_stall, w_redirect, w_hold;

   assign w_stall    = id_ex_mem_read & (id_ex_rt != '0) &
                       ((id_ex_rt == id_rs) | (id_uses_rt & (id_ex_rt == id_rt)));
   assign w_redirect = (ex_mem_branch & ex_mem_zero) | ex_mem_jump;
   assign w_hold     = w_stall & ~w_redirect;
   assign state      = r_state;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= IDLE;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_drain <= w_drain_nxt;
      end
   end

   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      w_state_nxt  = r_state;
      w_drain_nxt  = r_drain;
      case (r_state)
         IDLE: begin
            if (enable) w_state_nxt = RUN;
         end
         RUN: begin
            pc_en        = ~w_stall | w_redirect;
            if_id_en     = ~w_stall | w_redirect;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
            if_id_flush  = w_redirect;
            id_ex_flush  = w_stall | w_redirect;
            ex_mem_flush = w_redirect;
            if (!enable) begin
               w_state_nxt = DRAIN;
               w_drain_nxt = c_drain_load;
            end
         end
         DRAIN: begin
            // PC still follows a taken redirect so a later resume fetches the right path
            pc_en        = w_redirect;
            if_id_en     = ~w_stall | w_redirect;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = w_stall | w_redirect;
            ex_mem_flush = w_redirect;
            if (enable) begin
               w_state_nxt = RUN;
               w_drain_nxt = '0;
            end else if (!w_hold) begin
               if ((r_drain == '0) || (r_drain == c_drain_w'(1))) begin
                  w_state_nxt = IDLE;
                  w_drain_nxt = '0;
               end else begin
                  w_drain_nxt = r_drain - 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_drain_nxt = '0;
         end
      endcase
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && !(&v)) ? v + 1'b1 : v;
   endfunction

   logic w_run, w_active;
   assign w_run    = (r_state == RUN);
   assign w_active = (r_state == RUN) || (r_state == DRAIN);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cycle_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (clr_cnt) begin
         cycle_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         cycle_cnt <= sat_inc(cycle_cnt, w_run);
         stall_cnt <= sat_inc(stall_cnt, w_active & w_hold);
         flush_cnt <= sat_inc(flush_cnt, w_active & w_redirect);
      end
   end

endmodule
`default_nettype wire
